// File: rtl/ring_addr_sched_if.sv
// rtl/ring_addr_sched_if.sv - requester/RAM-side signal bundle for ring_addr_sched
// master = producer/consumer side, slave = the scheduler.
interface ring_addr_sched_if #(
  parameter int AW = 6
);
  logic          wr_req;
  logic          wr_gnt;
  logic          rd_req;
  logic          rd_gnt;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          chk_err;

  modport master (
    output wr_req, rd_req,
    input  wr_gnt, rd_gnt, ram_en, ram_we, ram_addr, rd_valid,
    input  full, empty, level, chk_err
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_gnt, rd_gnt, ram_en, ram_we, ram_addr, rd_valid,
    output full, empty, level, chk_err
  );
endinterface

// File: rtl/ring_addr_sched.sv
// rtl/ring_addr_sched.sv - single-port circular buffer address scheduler
// Optional shadow address check enabled by RING_ADDR_CHK_EN.
module ring_addr_sched #(
  parameter int AW   = 6,
  parameter int BASE = 48
) (
  input logic              clk,
  input logic              rst,
  ring_addr_sched_if.slave bus
);
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW:0]   PTR_RST   = {1'b0, BASE_ADDR};

  typedef enum logic {
    WIN_READ  = 1'b0,
    WIN_WRITE = 1'b1
  } win_e;

  win_e          last_win_q, last_win_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ram_en_q, ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [1:0]    rd_pipe_q;

  logic full, empty, wr_elig, rd_elig, wr_gnt, rd_gnt;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Round-robin only advances on contended cycles; lone grants leave last_win alone.
  always_comb begin
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    last_win_d = last_win_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_elig    = bus.wr_req && !full && !rst;
    rd_elig    = bus.rd_req && !empty && !rst;
    if (wr_elig && rd_elig) begin
      if (last_win_q == WIN_READ) begin
        wr_gnt     = 1'b1;
        last_win_d = WIN_WRITE;
      end else begin
        rd_gnt     = 1'b1;
        last_win_d = WIN_READ;
      end
    end else if (wr_elig) begin
      wr_gnt = 1'b1;
    end else if (rd_elig) begin
      rd_gnt = 1'b1;
    end
    if (wr_gnt) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_gnt) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_win_q <= WIN_READ;
      wr_ptr_q   <= PTR_RST;
      rd_ptr_q   <= PTR_RST;
    end else begin
      last_win_q <= last_win_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // RAM strobe one cycle after grant; read data lands one cycle later still.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= BASE_ADDR;
      rd_pipe_q  <= 2'b00;
    end else begin
      ram_en_q  <= wr_gnt || rd_gnt;
      ram_we_q  <= wr_gnt;
      rd_pipe_q <= {rd_pipe_q[0], rd_gnt};
      if (wr_gnt) begin
        ram_addr_q <= wr_ptr_q[AW-1:0];
      end else if (rd_gnt) begin
        ram_addr_q <= rd_ptr_q[AW-1:0];
      end
    end
  end

  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.rd_valid = rd_pipe_q[1];
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = wr_ptr_q - rd_ptr_q;

`ifdef RING_ADDR_CHK_EN
  logic [AW-1:0] cnt_q;
  logic          chk_err_q;
  logic [AW-1:0] shadow_addr;

  // Independent arithmetic form of the write address, compared against the pointer.
  assign shadow_addr = AW'((BASE + int'(cnt_q)) % (1 << AW));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (wr_gnt) begin
      cnt_q <= cnt_q + AW'(1);
      if (shadow_addr != wr_ptr_q[AW-1:0]) chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule
